// File: rtl/regfile_pkg.sv
// Shared register-file constants and the debug-walker state encoding.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_idx.sv
// Walk index for the register dump: range latch, next() with wrap and
// optional skip of register zero, and end-of-range detection.
module regfile_dump_idx
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter bit SKIP_ZERO  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_first,
  input  logic [ADDR_WIDTH-1:0] i_last,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_idx,
  output logic [ADDR_WIDTH-1:0] o_idx_next,
  output logic                  o_is_last,
  output logic                  o_empty
);

  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] IDX_ONES = {ADDR_WIDTH{1'b1}};

  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [ADDR_WIDTH-1:0] w_first_eff;
  logic [ADDR_WIDTH-1:0] w_last_eff;

  function automatic logic [ADDR_WIDTH-1:0] next_idx(input logic [ADDR_WIDTH-1:0] idx);
    logic [ADDR_WIDTH-1:0] n;
    n = idx + IDX_ONE;
    if (SKIP_ZERO && (n == IDX_ZERO)) begin
      n = IDX_ONE;
    end
    return n;
  endfunction

  // A last index of zero cannot be reached when zero is skipped, so the walk
  // ends at the top register instead; first=last=0 is an empty range.
  assign w_first_eff = (SKIP_ZERO && (i_first == IDX_ZERO)) ? IDX_ONE  : i_first;
  assign w_last_eff  = (SKIP_ZERO && (i_last  == IDX_ZERO)) ? IDX_ONES : i_last;
  assign o_empty     = SKIP_ZERO && (i_first == IDX_ZERO) && (i_last == IDX_ZERO);

  assign o_idx      = r_idx;
  assign o_idx_next = next_idx(r_idx);
  assign o_is_last  = (r_idx == r_last);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx  <= IDX_ZERO;
      r_last <= IDX_ZERO;
    end else if (i_load) begin
      r_idx  <= w_first_eff;
      r_last <= w_last_eff;
    end else if (i_advance) begin
      r_idx  <= o_idx_next;
    end else begin
      r_idx  <= r_idx;
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug reader that streams a range of the register file as (addr, data)
// beats on a valid/ready interface through one combinational read port.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter bit SKIP_ZERO  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_first_reg,
  input  logic [ADDR_WIDTH-1:0] i_last_reg,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [ADDR_WIDTH-1:0] o_out_addr,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_busy,
  output logic                  o_done
);

  dump_state_e           r_state;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_busy;
  logic                  r_done;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [ADDR_WIDTH-1:0] w_idx_next;
  logic                  w_is_last;
  logic                  w_empty;
  logic                  w_load;
  logic                  w_advance;

  assign w_load    = (r_state == ST_IDLE) && i_start && !w_empty;
  assign w_advance = (r_state == ST_SEND) && i_out_ready && !i_abort && !w_is_last;

  regfile_dump_idx #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SKIP_ZERO  (SKIP_ZERO)
  ) u_idx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_first    (i_first_reg),
    .i_last     (i_last_reg),
    .i_advance  (w_advance),
    .o_idx      (w_idx),
    .o_idx_next (w_idx_next),
    .o_is_last  (w_is_last),
    .o_empty    (w_empty)
  );

  // Look ahead one register during a handshake so back-to-back beats need no bubble.
  always_comb begin
    o_rd_addr = w_idx;
    if ((r_state == ST_SEND) && i_out_ready) begin
      o_rd_addr = w_idx_next;
    end else begin
      o_rd_addr = w_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_addr  <= {ADDR_WIDTH{1'b0}};
      r_out_data  <= {DATA_WIDTH{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && w_empty) begin
            r_done <= 1'b1;
          end else if (i_start) begin
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (i_abort) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_out_data  <= i_rd_data;
            r_out_addr  <= w_idx;
            r_out_valid <= 1'b1;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_abort) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (i_out_ready && w_is_last) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (i_out_ready) begin
            r_out_data <= i_rd_data;
            r_out_addr <= w_idx_next;
          end else begin
            r_state <= ST_SEND;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: directed dumps push expected beats, negedge monitors pop and compare.
module tb_regfile_dump_reader;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] mem [32];

  logic        a_start, a_abort, a_ready, a_valid, a_busy, a_done;
  logic [4:0]  a_first, a_last, a_rd_addr, a_addr;
  logic [31:0] a_rd_data, a_data;
  logic        b_start, b_abort, b_ready, b_valid, b_busy, b_done;
  logic [4:0]  b_first, b_last, b_rd_addr, b_addr;
  logic [31:0] b_rd_data, b_data;

  beat_t qa[$];
  beat_t qb[$];
  int checks = 0;
  int failures = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  logic        a_stall = 1'b0;
  logic [4:0]  a_prev_addr = 5'd0;
  logic [31:0] a_prev_data = 32'd0;

  always #5 clk = ~clk;

  assign a_rd_data = mem[a_rd_addr];
  assign b_rd_data = mem[b_rd_addr];

  regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SKIP_ZERO(1'b0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_first_reg(a_first),
    .i_last_reg(a_last), .i_abort(a_abort), .o_rd_addr(a_rd_addr),
    .i_rd_data(a_rd_data), .o_out_valid(a_valid), .i_out_ready(a_ready),
    .o_out_addr(a_addr), .o_out_data(a_data), .o_busy(a_busy), .o_done(a_done)
  );

  regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SKIP_ZERO(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_first_reg(b_first),
    .i_last_reg(b_last), .i_abort(b_abort), .o_rd_addr(b_rd_addr),
    .i_rd_data(b_rd_data), .o_out_valid(b_valid), .i_out_ready(b_ready),
    .o_out_addr(b_addr), .o_out_data(b_data), .o_busy(b_busy), .o_done(b_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int first, input int count);
    for (int k = 0; k < count; k++) begin
      qa.push_back('{a: 5'((first + k) % 32), d: mem[(first + k) % 32]});
    end
  endtask

  task automatic start_a(input logic [4:0] f, input logic [4:0] l);
    a_first = f;
    a_last  = l;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [4:0] f, input logic [4:0] l);
    b_first = f;
    b_last  = l;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    int n = 0;
    while (!a_done && n < 100) begin
      tick();
      n++;
    end
    chk(name, {31'd0, a_done}, 32'd1);
    chk({name, "_busy"}, {31'd0, a_busy}, 32'd0);
    tick();
  endtask

  task automatic wait_done_b(input string name);
    int n = 0;
    while (!b_done && n < 100) begin
      tick();
      n++;
    end
    chk(name, {31'd0, b_done}, 32'd1);
    chk({name, "_busy"}, {31'd0, b_busy}, 32'd0);
    tick();
  endtask

  task automatic wait_beat_a(input logic [4:0] addr);
    int n = 0;
    while (!(a_valid && a_addr == addr) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_beat_addr", {27'd0, a_addr}, {27'd0, addr});
  endtask

  // Monitor for the plain reader: scoreboard, hold-under-stall and done exclusivity.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      a_stall <= 1'b0;
    end else begin
      if (a_done) begin
        chk("a_done_excl_valid", {31'd0, a_valid}, 32'd0);
        a_done_cnt <= a_done_cnt + 1;
      end
      if (a_stall) begin
        chk("a_hold_valid", {31'd0, a_valid}, 32'd1);
        chk("a_hold_addr", {27'd0, a_addr}, {27'd0, a_prev_addr});
        chk("a_hold_data", a_data, a_prev_data);
      end
      if (a_valid && a_ready) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_beat actual addr=%0d required none", a_addr);
        end else begin
          e = qa.pop_front();
          chk("a_beat_addr", {27'd0, a_addr}, {27'd0, e.a});
          chk("a_beat_data", a_data, e.d);
        end
      end
      a_stall     <= a_valid && !a_ready;
      a_prev_addr <= a_addr;
      a_prev_data <= a_data;
    end
  end

  // Monitor for the zero-skipping reader.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (b_done) begin
        chk("b_done_excl_valid", {31'd0, b_valid}, 32'd0);
        b_done_cnt <= b_done_cnt + 1;
      end
      if (b_valid && b_ready) begin
        if (qb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_beat actual addr=%0d required none", b_addr);
        end else begin
          e = qb.pop_front();
          chk("b_beat_addr", {27'd0, b_addr}, {27'd0, e.a});
          chk("b_beat_data", b_data, e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1; a_first = 5'd0; a_last = 5'd0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1; b_first = 5'd0; b_last = 5'd0;
    for (int k = 0; k < 32; k++) mem[k] = 32'(k * 4);
    tick();
    tick();
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_done", {31'd0, a_done}, 32'd0);
    chk("rst_addr", {27'd0, a_addr}, 32'd0);
    chk("rst_data", a_data, 32'd0);
    rst = 1'b0;
    tick();

    // Full dump, ready held high: 2-cycle latency then 32 back-to-back beats.
    push_a(0, 32);
    start_a(5'd0, 5'd31);
    chk("full_lat_busy", {31'd0, a_busy}, 32'd1);
    chk("full_lat_valid", {31'd0, a_valid}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("full_stream_valid", {31'd0, a_valid}, 32'd1);
      chk("full_stream_addr", {27'd0, a_addr}, 32'(k));
    end
    tick();
    chk("full_done", {31'd0, a_done}, 32'd1);
    chk("full_busy_fall", {31'd0, a_busy}, 32'd0);
    chk("full_valid_fall", {31'd0, a_valid}, 32'd0);
    tick();
    chk("full_done_single", {31'd0, a_done}, 32'd0);

    // Wrapping range 30..1.
    push_a(30, 4);
    start_a(5'd30, 5'd1);
    wait_done_a("wrap_done");

    // Backpressure on beat 5 while register 5 is overwritten.
    push_a(4, 4);
    start_a(5'd4, 5'd7);
    wait_beat_a(5'd5);
    a_ready = 1'b0;
    mem[5] = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_stall_addr", {27'd0, a_addr}, 32'd5);
      chk("bp_stall_data", a_data, 32'd20);
    end
    a_ready = 1'b1;
    tick();
    chk("bp_next_valid", {31'd0, a_valid}, 32'd1);
    chk("bp_next_addr", {27'd0, a_addr}, 32'd6);
    wait_done_a("bp_done");
    mem[5] = 32'd20;

    // Single-register range.
    push_a(7, 1);
    start_a(5'd7, 5'd7);
    wait_done_a("single_done");

    // Zero-skipping walk 31..2 and the empty 0..0 range.
    qb.push_back('{a: 5'd31, d: 32'd124});
    qb.push_back('{a: 5'd1,  d: 32'd4});
    qb.push_back('{a: 5'd2,  d: 32'd8});
    start_b(5'd31, 5'd2);
    wait_done_b("skip_done");
    start_b(5'd0, 5'd0);
    wait_done_b("skip_empty_done");

    // Start while busy is ignored; abort on beat 3 ends the dump without done.
    push_a(0, 4);
    start_a(5'd0, 5'd31);
    wait_beat_a(5'd1);
    a_first = 5'd20;
    a_last  = 5'd25;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("busy_start_addr", {27'd0, a_addr}, 32'd2);
    wait_beat_a(5'd3);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("abort_valid", {31'd0, a_valid}, 32'd0);
    chk("abort_busy", {31'd0, a_busy}, 32'd0);
    chk("abort_done", {31'd0, a_done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_idle_valid", {31'd0, a_valid}, 32'd0);
    end

    // Reset mid-dump, then a normal dump afterwards.
    push_a(0, 2);
    start_a(5'd0, 5'd31);
    wait_beat_a(5'd2);
    rst = 1'b1;
    tick();
    chk("mrst_valid", {31'd0, a_valid}, 32'd0);
    chk("mrst_busy", {31'd0, a_busy}, 32'd0);
    chk("mrst_done", {31'd0, a_done}, 32'd0);
    chk("mrst_addr", {27'd0, a_addr}, 32'd0);
    chk("mrst_data", a_data, 32'd0);
    rst = 1'b0;
    tick();
    push_a(10, 3);
    start_a(5'd10, 5'd12);
    chk("post_busy", {31'd0, a_busy}, 32'd1);
    chk("post_valid0", {31'd0, a_valid}, 32'd0);
    tick();
    chk("post_valid1", {31'd0, a_valid}, 32'd1);
    chk("post_addr", {27'd0, a_addr}, 32'd10);
    wait_done_a("post_done");

    tick();
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    chk("a_done_count", 32'(a_done_cnt), 32'd5);
    chk("b_done_count", 32'(b_done_cnt), 32'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
